coinc_window_readout: RTL and testbench

- Sits directly downstream of the per-channel delay and positive-edge-detect stage.
- Consumes one-cycle per-channel pulses and counts two-fold coincidences for every unordered channel pair over a programmable integration window.
- At each window end it snapshots all pair counts and streams them out one pair per beat over a valid/ready interface to the host/readout logic.

---
 rtl/coinc_window_readout.sv | 167 ++++++++++++++++
 tb/tb_coinc_window_readout.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_window_readout.sv
// Two-fold coincidence counter for every unordered channel pair, integrated over a
// programmable window and streamed out one pair per beat on a valid/ready port.
module coinc_window_readout #(
  parameter int NCHAN = 4,
  parameter int CBITS = 16,
  parameter int WBITS = 16,
  parameter int IBITS = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NCHAN-1:0] Pulses,
  input  logic             Enable,
  input  logic [WBITS-1:0] WindowLen,
  input  logic             OutReady,
  output logic             OutValid,
  output logic [CBITS-1:0] OutData,
  output logic [IBITS-1:0] OutIndex,
  output logic             OutLast,
  input  logic             ClrOvr,
  output logic             Overrun
);

  localparam int NPAIR = NCHAN * (NCHAN - 1) / 2;
  localparam int NSLOT = 2 ** IBITS;
  localparam logic [IBITS-1:0] LASTIDX = IBITS'(NPAIR - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Pair k enumerates (0,1),(0,2)..(0,N-1),(1,2).. ; these recover the two channels.
  function automatic int pair_lo(input int k);
    int r;
    r = k;
    for (int i = 0; i < NCHAN; i++) begin
      if (r < NCHAN - 1 - i) return i;
      r = r - (NCHAN - 1 - i);
    end
    return 0;
  endfunction

  function automatic int pair_hi(input int k);
    int r;
    r = k;
    for (int i = 0; i < NCHAN; i++) begin
      if (r < NCHAN - 1 - i) return i + 1 + r;
      r = r - (NCHAN - 1 - i);
    end
    return 1;
  endfunction

  function automatic logic [CBITS-1:0] sat_inc(input logic [CBITS-1:0] v, input logic b);
    if (b && (v != {CBITS{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  logic [WBITS-1:0] len_q;
  logic [WBITS-1:0] len_eff;
  logic [WBITS-1:0] timer_q;
  logic             start_q;
  logic             active;
  logic             win_end;

  state_t           state_q, state_d;
  logic [IBITS-1:0] idx_q, idx_d;
  logic             load_snap;
  logic             ovr_set;
  logic             xfer;
  logic             ovr_q;

  logic [CBITS-1:0] snap_w [NSLOT];

  // WindowLen is taken live on a window's first cycle, then held for the rest of it.
  assign len_eff = start_q ? WindowLen : len_q;
  assign active  = Enable && (len_eff != '0);
  assign win_end = active && (timer_q == len_eff - 1'b1);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      len_q   <= '0;
      timer_q <= '0;
      start_q <= 1'b1;
    end else begin
      len_q   <= len_eff;
      start_q <= !active || win_end;
      if (!active || win_end) timer_q <= '0;
      else                    timer_q <= timer_q + 1'b1;
    end
  end

  for (genvar k = 0; k < NPAIR; k++) begin : g_pair
    localparam int A = pair_lo(k);
    localparam int B = pair_hi(k);
    logic             inc;
    logic [CBITS-1:0] cnt_q;
    logic [CBITS-1:0] sum;
    logic [CBITS-1:0] snap_q;

    assign inc = Pulses[A] & Pulses[B];
    // The snapshot takes sum so that pulses in the window-end cycle are included.
    assign sum = sat_inc(cnt_q, inc);

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)                     cnt_q <= '0;
      else if (!Enable || win_end) cnt_q <= '0;
      else if (active)             cnt_q <= sum;
    end

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)            snap_q <= '0;
      else if (load_snap) snap_q <= sum;
    end

    assign snap_w[k] = snap_q;
  end

  for (genvar p = NPAIR; p < NSLOT; p++) begin : g_pad
    assign snap_w[p] = '0;
  end

  // Readout: a window end on the final transfer reloads without a bubble.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_snap = 1'b0;
    ovr_set   = 1'b0;
    xfer      = (state_q == SEND) && OutReady;
    case (state_q)
      IDLE: begin
        if (win_end) begin
          state_d   = SEND;
          idx_d     = '0;
          load_snap = 1'b1;
        end
      end
      SEND: begin
        if (xfer && (idx_q == LASTIDX)) begin
          idx_d = '0;
          if (win_end) load_snap = 1'b1;
          else         state_d   = IDLE;
        end else begin
          if (xfer)    idx_d   = idx_q + 1'b1;
          if (win_end) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (ovr_set)     ovr_q <= 1'b1;
      else if (ClrOvr) ovr_q <= 1'b0;
    end
  end

  assign OutValid = (state_q == SEND);
  assign OutIndex = idx_q;
  assign OutData  = snap_w[idx_q];
  assign OutLast  = (state_q == SEND) && (idx_q == LASTIDX);
  assign Overrun  = ovr_q;

endmodule

// File: tb/tb_coinc_window_readout.sv
// Scoreboard bench for coinc_window_readout: expected beats queued per window,
// checked by a monitor on every transfer; scenario tasks check control outputs.
module tb_coinc_window_readout;

  localparam int NCHAN = 4;
  localparam int CBITS = 8;
  localparam int WBITS = 16;
  localparam int IBITS = 3;
  localparam int NPAIR = 6;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NCHAN-1:0] Pulses;
  logic             Enable;
  logic [WBITS-1:0] WindowLen;
  logic             OutReady;
  logic             OutValid;
  logic [CBITS-1:0] OutData;
  logic [IBITS-1:0] OutIndex;
  logic             OutLast;
  logic             ClrOvr;
  logic             Overrun;

  typedef struct {
    logic [CBITS-1:0] data;
    logic [IBITS-1:0] idx;
    logic             last;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  coinc_window_readout #(.NCHAN(NCHAN), .CBITS(CBITS), .WBITS(WBITS), .IBITS(IBITS)) dut (
    .Clk(Clk), .Rst(Rst), .Pulses(Pulses), .Enable(Enable), .WindowLen(WindowLen),
    .OutReady(OutReady), .OutValid(OutValid), .OutData(OutData), .OutIndex(OutIndex),
    .OutLast(OutLast), .ClrOvr(ClrOvr), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  always @(negedge Clk) begin
    beat_t e;
    if (Rst === 1'b0 && OutValid === 1'b1 && OutReady === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got idx=%0d data=%0d, expected no beat", OutIndex, OutData);
      end else begin
        e = sb.pop_front();
        if (OutData !== e.data || OutIndex !== e.idx || OutLast !== e.last) begin
          n_bad++;
          $display("FAIL beat: got idx=%0d data=%0d last=%0b, expected idx=%0d data=%0d last=%0b",
                   OutIndex, OutData, OutLast, e.idx, e.data, e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_win(input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5);
    int v[6];
    beat_t b;
    v = '{a0, a1, a2, a3, a4, a5};
    for (int k = 0; k < NPAIR; k++) begin
      b.data = CBITS'(v[k]);
      b.idx  = IBITS'(k);
      b.last = (k == NPAIR - 1);
      sb.push_back(b);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (sb.size() == 0 && OutValid === 1'b0) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_drain: %0d beats outstanding, OutValid=%0b, required 0 and 0", name, sb.size(), OutValid);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (OutValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b, expected 0", OutValid); end
    n_cmp++; if (OutData !== '0) begin n_bad++; $display("FAIL reset_data: got %0d, expected 0", OutData); end
    n_cmp++; if (OutIndex !== '0) begin n_bad++; $display("FAIL reset_index: got %0d, expected 0", OutIndex); end
    n_cmp++; if (OutLast !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %0b, expected 0", OutLast); end
    n_cmp++; if (Overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %0b, expected 0", Overrun); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    WindowLen = 16'd10;
    OutReady  = 1'b1;
    push_win(3, 1, 1, 1, 1, 1);
    Enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      Pulses = (c == 2 || c == 5) ? 4'b0011 : (c == 7) ? 4'b1111 : 4'b0000;
      if (c == 9) begin
        n_cmp++;
        if (OutValid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_early: got %0b in cycle E, expected 0", OutValid); end
      end
      tick();
    end
    Pulses = '0;
    Enable = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_rise: got %0b in cycle E+1, expected 1", OutValid); end
    drain("basic");
  endtask

  task automatic test_end_cycle();
    WindowLen = 16'd10;
    push_win(0, 1, 0, 0, 0, 0);
    push_win(0, 0, 0, 0, 0, 0);
    Enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      Pulses = (c == 9) ? 4'b0101 : 4'b0000;
      tick();
    end
    Pulses = '0;
    Enable = 1'b0;
    drain("end_cycle");
  endtask

  task automatic test_saturate();
    WindowLen = 16'd20;
    for (int w = 0; w < 15; w++) push_win(20, 0, 0, 0, 0, 0);
    Enable = 1'b1;
    Pulses = 4'b0011;
    for (int c = 0; c < 300; c++) tick();
    Pulses = '0;
    Enable = 1'b0;
    drain("count20");
    WindowLen = 16'd300;
    push_win(255, 0, 0, 0, 0, 0);
    Enable = 1'b1;
    Pulses = 4'b0011;
    for (int c = 0; c < 300; c++) tick();
    Pulses = '0;
    Enable = 1'b0;
    drain("saturate");
  endtask

  task automatic test_overrun();
    WindowLen = 16'd4;
    OutReady  = 1'b0;
    push_win(1, 1, 1, 1, 1, 1);
    Enable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      Pulses = (c == 1) ? 4'b1111 : (c >= 4) ? 4'b0011 : 4'b0000;
      if (c >= 4) begin
        n_cmp++;
        if (OutValid !== 1'b1 || OutIndex !== '0 || OutData !== 8'd1) begin
          n_bad++;
          $display("FAIL overrun_hold c=%0d: got valid=%0b idx=%0d data=%0d, expected 1/0/1", c, OutValid, OutIndex, OutData);
        end
      end
      tick();
    end
    n_cmp++;
    if (Overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_set: got %0b, expected 1", Overrun); end
    Pulses   = '0;
    Enable   = 1'b0;
    OutReady = 1'b1;
    drain("overrun");
    n_cmp++;
    if (Overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %0b, expected 1", Overrun); end
    ClrOvr = 1'b1;
    tick();
    ClrOvr = 1'b0;
    n_cmp++;
    if (Overrun !== 1'b0) begin n_bad++; $display("FAIL overrun_clear: got %0b, expected 0", Overrun); end
  endtask

  task automatic test_back_to_back();
    int gaps;
    gaps = 0;
    WindowLen = 16'd6;
    OutReady  = 1'b1;
    push_win(1, 0, 0, 0, 0, 0);
    push_win(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 19; c++) begin
      Enable = (c < 12);
      Pulses = (c == 0) ? 4'b0011 : (c == 6) ? 4'b1100 : 4'b0000;
      if (c >= 6 && c <= 17 && OutValid !== 1'b1) gaps++;
      if (c == 18) begin
        n_cmp++;
        if (OutValid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got %0b, expected 0", OutValid); end
      end
      tick();
    end
    n_cmp++;
    if (gaps != 0) begin n_bad++; $display("FAIL b2b_gaps: got %0d idle cycles, expected 0", gaps); end
    n_cmp++;
    if (Overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %0b, expected 0", Overrun); end
    Pulses = '0;
    Enable = 1'b0;
    drain("b2b");
  endtask

  task automatic test_reset_midstream();
    WindowLen = 16'd10;
    OutReady  = 1'b1;
    push_win(1, 1, 1, 1, 1, 1);
    Enable = 1'b1;
    for (int c = 0; c < 13; c++) begin
      Pulses = (c == 0 || c >= 10) ? 4'b1111 : 4'b0000;
      tick();
    end
    n_cmp++;
    if (OutIndex !== 3'd3 || OutValid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_pre: got valid=%0b idx=%0d, expected 1/3", OutValid, OutIndex);
    end
    Rst = 1'b1;
    #1;
    n_cmp++;
    if (OutValid !== 1'b0 || OutIndex !== '0) begin
      n_bad++; $display("FAIL midrst_async: got valid=%0b idx=%0d, expected 0/0", OutValid, OutIndex);
    end
    sb.delete();
    Pulses = '0;
    Enable = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    push_win(0, 0, 0, 1, 0, 0);
    Enable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      Pulses = (c == 3) ? 4'b0110 : 4'b0000;
      tick();
    end
    Pulses = '0;
    Enable = 1'b0;
    n_cmp++;
    if (OutValid !== 1'b1 || OutIndex !== '0) begin
      n_bad++; $display("FAIL midrst_restart: got valid=%0b idx=%0d, expected 1/0", OutValid, OutIndex);
    end
    drain("midrst");
  endtask

  initial begin
    Rst       = 1'b1;
    Pulses    = '0;
    Enable    = 1'b0;
    WindowLen = 16'd10;
    OutReady  = 1'b1;
    ClrOvr    = 1'b0;
    test_reset();
    test_basic();
    test_end_cycle();
    test_saturate();
    test_overrun();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
